tmr_alu_pipe: RTL and testbench

//  Parametrised, pipelined triple-modular-redundant ALU with valid/ready handshake.

---
 rtl/tmr_alu_pipe.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_tmr_alu_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_alu_pipe.sv
// -----------------------------------------------------------------------------
// tmr_alu_pipe
//   Two-stage triple-modular-redundant ALU with a valid/ready handshake.
//   Stage 1 holds three independent copies of the operands and op select;
//   three ALU replicas evaluate those copies, a bitwise majority voter merges
//   their {result, zero} words, and stage 2 registers the voted output.
//   A replica that dissents FAIL_THRESH times in a row is retired, after which
//   the block runs in dual-modular mode on the two remaining replicas.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   a, b, alucont       operands and op select
//   out_valid/out_ready result handshake
//   result, zero        voted result and zero flag
//   err_corrected       result had exactly one dissenting replica (TMR)
//   err_uncorr          result had no trustworthy majority
//   replica_failed      sticky per-replica failed flags
//   degraded            0 = TMR, 1 = DMR
//   err_count           saturating count of corrected results
//   clear_fail          clears failed flags, disagreement counters, degraded
//   inj_en, inj_mask    fault injection: mask XORed into enabled replicas
// -----------------------------------------------------------------------------
module tmr_alu_pipe #(
  parameter int WIDTH       = 32,
  parameter int FAIL_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucont,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err_corrected,
  output logic             err_uncorr,
  output logic [2:0]       replica_failed,
  output logic             degraded,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear_fail,
  input  logic [2:0]       inj_en,
  input  logic [WIDTH-1:0] inj_mask
);

  localparam int          VW       = WIDTH + 1;
  localparam int          DCW      = 8;
  localparam logic [DCW-1:0] THRESH_C = DCW'(FAIL_THRESH);

  // One ALU replica: add/sub share the adder through the inverted-b carry-in.
  function automatic logic [WIDTH-1:0] alu_calc(
    input logic [WIDTH-1:0] a_in,
    input logic [WIDTH-1:0] b_in,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] sum;
    b2  = op[2] ? ~b_in : b_in;
    sum = a_in + b2 + {{(WIDTH-1){1'b0}}, op[2]};
    case (op[1:0])
      2'b00:   alu_calc = a_in & b_in;
      2'b01:   alu_calc = a_in | b_in;
      2'b10:   alu_calc = sum;
      2'b11:   alu_calc = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
      default: alu_calc = {WIDTH{1'b0}};
    endcase
  endfunction

  // Bitwise two-out-of-three majority.
  function automatic logic [VW-1:0] majority3(
    input logic [VW-1:0] w0,
    input logic [VW-1:0] w1,
    input logic [VW-1:0] w2
  );
    majority3 = (w0 & w1) | (w0 & w2) | (w1 & w2);
  endfunction

  // Stage-1 replica copies
  logic             s1_valid_r;
  logic [WIDTH-1:0] a_r   [3];
  logic [WIDTH-1:0] b_r   [3];
  logic [2:0]       op_r  [3];

  // Replica outputs and vote
  logic [WIDTH-1:0] rep_res_s  [3];
  logic [VW-1:0]    rep_word_s [3];
  logic [VW-1:0]    vote_word_s;
  logic [2:0]       dissent_s;
  logic [1:0]       dissent_cnt_s;
  logic [VW-1:0]    out_word_s;
  logic             corr_s;
  logic             uncorr_s;

  // Health tracking state
  logic [DCW-1:0]   dis_cnt_r   [3];
  logic [DCW-1:0]   dis_cnt_nxt_s [3];
  logic [2:0]       failed_r;
  logic [2:0]       failed_nxt_s;
  logic             degraded_r;
  logic             degraded_nxt_s;
  logic [CNT_W-1:0] err_count_r;
  logic [CNT_W-1:0] err_count_nxt_s;

  // Stage-2 registers
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             corr_r;
  logic             uncorr_r;

  logic             s2_load_s;
  logic             s1_load_s;
  logic             track_s;

  // Handshake: stage 2 advances when empty or drained; stage 1 follows it.
  always_comb begin
    s2_load_s = !out_valid_r || out_ready;
    s1_load_s = !s1_valid_r || s2_load_s;
    in_ready  = s1_load_s;
    // health tracking only reacts to real operations entering stage 2
    track_s   = s2_load_s && s1_valid_r;
  end

  // Stage 1: three independent operand/op copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        a_r[i]  <= {WIDTH{1'b0}};
        b_r[i]  <= {WIDTH{1'b0}};
        op_r[i] <= 3'b000;
      end
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      for (int i = 0; i < 3; i++) begin
        a_r[i]  <= a;
        b_r[i]  <= b;
        op_r[i] <= alucont;
      end
    end
  end

  // Replicas, injection, voting and DMR selection.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rep_res_s[i]  = alu_calc(a_r[i], b_r[i], op_r[i]) ^
                      (inj_en[i] ? inj_mask : {WIDTH{1'b0}});
      // zero is derived after injection so a corrupted replica is self-consistent
      rep_word_s[i] = {rep_res_s[i], (rep_res_s[i] == {WIDTH{1'b0}})};
    end
    vote_word_s = majority3(rep_word_s[0], rep_word_s[1], rep_word_s[2]);
    for (int i = 0; i < 3; i++) begin
      dissent_s[i] = (rep_word_s[i] != vote_word_s);
    end
    dissent_cnt_s = {1'b0, dissent_s[0]} + {1'b0, dissent_s[1]} + {1'b0, dissent_s[2]};

    out_word_s = vote_word_s;
    corr_s     = 1'b0;
    uncorr_s   = 1'b0;
    if (degraded_r) begin
      // output follows the lower-index healthy replica of the surviving pair
      if (failed_r[0]) begin
        out_word_s = rep_word_s[1];
        uncorr_s   = (rep_word_s[1] != rep_word_s[2]);
      end else if (failed_r[1]) begin
        out_word_s = rep_word_s[0];
        uncorr_s   = (rep_word_s[0] != rep_word_s[2]);
      end else begin
        out_word_s = rep_word_s[0];
        uncorr_s   = (rep_word_s[0] != rep_word_s[1]);
      end
    end else begin
      corr_s   = (dissent_cnt_s == 2'd1);
      uncorr_s = (dissent_cnt_s >= 2'd2);
    end
  end

  // Next-state for disagreement counters, failed flags, mode and err_count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dis_cnt_nxt_s[i] = dis_cnt_r[i];
    end
    failed_nxt_s    = failed_r;
    degraded_nxt_s  = degraded_r;
    err_count_nxt_s = err_count_r;

    if (clear_fail) begin
      // clear wins over a threshold hit on the same edge
      for (int i = 0; i < 3; i++) begin
        dis_cnt_nxt_s[i] = {DCW{1'b0}};
      end
      failed_nxt_s   = 3'b000;
      degraded_nxt_s = 1'b0;
    end else if (track_s && !degraded_r && (dissent_cnt_s <= 2'd1)) begin
      for (int i = 0; i < 3; i++) begin
        if (dissent_s[i]) begin
          dis_cnt_nxt_s[i] = dis_cnt_r[i] + 8'd1;
        end else begin
          dis_cnt_nxt_s[i] = {DCW{1'b0}};
        end
        // only one replica can dissent here, so at most one can fail
        if (dis_cnt_nxt_s[i] == THRESH_C) begin
          failed_nxt_s[i] = 1'b1;
          degraded_nxt_s  = 1'b1;
        end else begin
          failed_nxt_s[i] = failed_r[i];
        end
      end
    end else begin
      failed_nxt_s   = failed_r;
      degraded_nxt_s = degraded_r;
    end

    if (track_s && !degraded_r && (dissent_cnt_s == 2'd1) &&
        (err_count_r != {CNT_W{1'b1}})) begin
      err_count_nxt_s = err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_nxt_s = err_count_r;
    end
  end

  // Health tracking state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        dis_cnt_r[i] <= {DCW{1'b0}};
      end
      failed_r    <= 3'b000;
      degraded_r  <= 1'b0;
      err_count_r <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < 3; i++) begin
        dis_cnt_r[i] <= dis_cnt_nxt_s[i];
      end
      failed_r    <= failed_nxt_s;
      degraded_r  <= degraded_nxt_s;
      err_count_r <= err_count_nxt_s;
    end
  end

  // Stage 2: voted output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      corr_r      <= 1'b0;
      uncorr_r    <= 1'b0;
    end else if (s2_load_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= out_word_s[VW-1:1];
        zero_r   <= out_word_s[0];
        corr_r   <= corr_s;
        uncorr_r <= uncorr_s;
      end else begin
        // bubble: keep the last data, drop the per-result flags
        corr_r   <= 1'b0;
        uncorr_r <= 1'b0;
      end
    end
  end

  // Output wiring.
  always_comb begin
    out_valid      = out_valid_r;
    result         = result_r;
    zero           = zero_r;
    err_corrected  = corr_r;
    err_uncorr     = uncorr_r;
    replica_failed = failed_r;
    degraded       = degraded_r;
    err_count      = err_count_r;
  end

endmodule

// File: tb/tb_tmr_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_tmr_alu_pipe
//   Directed self-checking bench for tmr_alu_pipe (WIDTH=32, FAIL_THRESH=4).
//   Inputs change #1 after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_tmr_alu_pipe;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alucont;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err_corrected;
  logic             err_uncorr;
  logic [2:0]       replica_failed;
  logic             degraded;
  logic [CNT_W-1:0] err_count;
  logic             clear_fail;
  logic [2:0]       inj_en;
  logic [WIDTH-1:0] inj_mask;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  tmr_alu_pipe #(.WIDTH(WIDTH), .FAIL_THRESH(4), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .alucont        (alucont),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .zero           (zero),
    .err_corrected  (err_corrected),
    .err_uncorr     (err_uncorr),
    .replica_failed (replica_failed),
    .degraded       (degraded),
    .err_count      (err_count),
    .clear_fail     (clear_fail),
    .inj_en         (inj_en),
    .inj_mask       (inj_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one op into an empty pipe with out_ready=1; result visible after two edges.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [2:0] op);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    a        = av;
    b        = bv;
    alucont  = op;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("op_latency_valid", {63'd0, out_valid}, 64'd1);
  endtask

  logic [2:0]  s_ops [5];
  logic [31:0] s_res [5];
  logic        s_zro [5];

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    alucont    = 3'b000;
    out_ready  = 1'b1;
    clear_fail = 1'b0;
    inj_en     = 3'b000;
    inj_mask   = 32'd0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // reset state
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_err_count", {48'd0, err_count}, 64'd0);
    check("rst_failed", {61'd0, replica_failed}, 64'd0);
    check("rst_degraded", {63'd0, degraded}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // back-to-back stream a=5, b=3
    s_ops[0] = 3'b010; s_res[0] = 32'd8; s_zro[0] = 1'b0;
    s_ops[1] = 3'b110; s_res[1] = 32'd2; s_zro[1] = 1'b0;
    s_ops[2] = 3'b111; s_res[2] = 32'd0; s_zro[2] = 1'b1;
    s_ops[3] = 3'b000; s_res[3] = 32'd1; s_zro[3] = 1'b0;
    s_ops[4] = 3'b001; s_res[4] = 32'd7; s_zro[4] = 1'b0;
    a = 32'd5;
    b = 32'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alucont = s_ops[i];
      step();
      if (i == 0) begin
        check("stream_first_valid_low", {63'd0, out_valid}, 64'd0);
      end else begin
        check("stream_valid", {63'd0, out_valid}, 64'd1);
        check("stream_result", {32'd0, result}, {32'd0, s_res[i-1]});
        check("stream_zero", {63'd0, zero}, {63'd0, s_zro[i-1]});
      end
    end
    in_valid = 1'b0;
    step();
    check("stream_last_result", {32'd0, result}, {32'd0, s_res[4]});
    check("stream_last_zero", {63'd0, zero}, {63'd0, s_zro[4]});
    step();
    check("stream_drained", {63'd0, out_valid}, 64'd0);

    // subtract to zero and signed overflow add
    run_op(32'd7, 32'd7, 3'b110);
    check("sub_zero_result", {32'd0, result}, 64'd0);
    check("sub_zero_flag", {63'd0, zero}, 64'd1);
    run_op(32'h7FFF_FFFF, 32'd1, 3'b010);
    check("ovf_result", {32'd0, result}, 64'h8000_0000);
    check("ovf_zero", {63'd0, zero}, 64'd0);
    check("ovf_corr", {63'd0, err_corrected}, 64'd0);
    check("ovf_uncorr", {63'd0, err_uncorr}, 64'd0);

    // single-replica fault on replica 0 until it is retired
    inj_en   = 3'b001;
    inj_mask = 32'd1;
    for (int i = 1; i <= 4; i++) begin
      run_op(32'd5, 32'd3, 3'b010);
      check("inj_result", {32'd0, result}, 64'd8);
      check("inj_corr", {63'd0, err_corrected}, 64'd1);
      check("inj_uncorr", {63'd0, err_uncorr}, 64'd0);
      check("inj_err_count", {48'd0, err_count}, i);
      if (i < 4) begin
        check("inj_not_failed_yet", {61'd0, replica_failed}, 64'd0);
      end else begin
        check("inj_failed", {61'd0, replica_failed}, 64'd1);
        check("inj_degraded", {63'd0, degraded}, 64'd1);
      end
    end

    // DMR on replicas 1 and 2; output follows replica 1
    inj_en   = 3'b100;
    inj_mask = 32'd1;
    run_op(32'd1, 32'd1, 3'b010);
    check("dmr_r2_result", {32'd0, result}, 64'd2);
    check("dmr_r2_uncorr", {63'd0, err_uncorr}, 64'd1);
    check("dmr_r2_corr", {63'd0, err_corrected}, 64'd0);
    inj_en = 3'b010;
    run_op(32'd1, 32'd1, 3'b010);
    // replica 1 is itself corrupted (2 ^ 1) and still drives the output
    check("dmr_r1_result", {32'd0, result}, 64'd3);
    check("dmr_r1_uncorr", {63'd0, err_uncorr}, 64'd1);
    check("dmr_err_count_frozen", {48'd0, err_count}, 64'd4);
    check("dmr_still_failed", {61'd0, replica_failed}, 64'd1);

    // clear_fail restores TMR, keeps err_count
    inj_en     = 3'b000;
    clear_fail = 1'b1;
    step();
    clear_fail = 1'b0;
    check("clr_failed", {61'd0, replica_failed}, 64'd0);
    check("clr_degraded", {63'd0, degraded}, 64'd0);
    check("clr_err_count", {48'd0, err_count}, 64'd4);

    // two replicas carrying the same corruption outvote the clean one
    inj_en   = 3'b011;
    inj_mask = 32'd1;
    run_op(32'd5, 32'd3, 3'b010);
    check("pair_inj_result", {32'd0, result}, 64'd9);
    check("pair_inj_corr", {63'd0, err_corrected}, 64'd1);
    check("pair_inj_err_count", {48'd0, err_count}, 64'd5);
    inj_en = 3'b000;
    step();
    check("pair_drained", {63'd0, out_valid}, 64'd0);

    // stall: out_ready low, three ops offered, two accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 32'd2; b = 32'd3; alucont = 3'b010;
    step();
    check("stall_accept1_ready", {63'd0, in_ready}, 64'd1);
    a = 32'd9; b = 32'd4; alucont = 3'b110;
    step();
    check("stall_valid", {63'd0, out_valid}, 64'd1);
    check("stall_ready_low", {63'd0, in_ready}, 64'd0);
    a = 32'd1; b = 32'd1; alucont = 3'b001;
    step();
    step();
    check("stall_result_held", {32'd0, result}, 64'd5);
    check("stall_ready_still_low", {63'd0, in_ready}, 64'd0);
    check("stall_valid_held", {63'd0, out_valid}, 64'd1);

    // asynchronous reset mid-stall
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_result", {32'd0, result}, 64'd0);
    check("arst_err_count", {48'd0, err_count}, 64'd0);
    check("arst_flags", {61'd0, err_corrected, err_uncorr, degraded}, 64'd0);
    check("arst_failed", {61'd0, replica_failed}, 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
